// File: rtl/lane_obstacle_engine.sv
// Horizontally scrolling obstacle lanes with frog collision detection and a play/hit/over FSM.
// Build option: define DIFFICULTY_RAMP_EN to add one px/frame to every lane each 600 played frames (max +3).
module lane_obstacle_engine #(
    parameter int NUM_LANES  = 4,
    parameter int LANE_Y0    = 292,
    parameter int LANE_H     = 32,
    parameter int OBJ_W      = 64,
    parameter int SCREEN_W   = 640,
    parameter int BASE_SPEED = 1,
    parameter int FROG_SIZE  = 28,
    parameter int LIVES      = 3,
    parameter int HIT_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       restart,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       video_on,
    input  logic [9:0] frog_x_l,
    input  logic [9:0] frog_y_t,
    output logic       obj_on,
    output logic [2:0] obj_lane,
    output logic       hit,
    output logic       freeze,
    output logic [1:0] lives,
    output logic       game_over
);
    localparam int CNT_W = $clog2(HIT_FRAMES + 1);

    typedef enum logic [1:0] {PLAY, HIT, OVER} state_t;

    state_t                     state;
    logic [NUM_LANES-1:0][10:0] lane_x;
    logic [NUM_LANES-1:0][10:0] step_x;
    logic [NUM_LANES-1:0]       lane_pix;
    logic [CNT_W-1:0]           hit_cnt;
    logic                       overlap;
    logic                       pix_on;
    logic [2:0]                 pix_lane;
    logic                       frog_box;
    logic [1:0]                 extra;
    logic [10:0]                x_ext, y_ext, fx_ext, fy_ext;

    assign x_ext  = {1'b0, x};
    assign y_ext  = {1'b0, y};
    assign fx_ext = {1'b0, frog_x_l};
    assign fy_ext = {1'b0, frog_y_t};

    function automatic logic [10:0] home_x(input int i);
        return 11'((i * 160) % SCREEN_W);
    endfunction

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [10:0] speed;
        logic [10:0] dx;
        logic        in_rows;

        assign speed = 11'(BASE_SPEED + gi) + {9'd0, extra};

        if (gi % 2 == 0) begin : g_right
            logic [10:0] sum;
            assign sum         = lane_x[gi] + speed;
            assign step_x[gi]  = (sum >= 11'(SCREEN_W)) ? sum - 11'(SCREEN_W) : sum;
        end else begin : g_left
            assign step_x[gi]  = (lane_x[gi] < speed) ? lane_x[gi] + 11'(SCREEN_W) - speed
                                                      : lane_x[gi] - speed;
        end

        // Distance right of the obstacle's left edge, modulo the screen, so wrapped cars split cleanly.
        assign dx = (x_ext >= lane_x[gi]) ? x_ext - lane_x[gi]
                                          : x_ext + 11'(SCREEN_W) - lane_x[gi];
        assign in_rows = (y_ext >= 11'(LANE_Y0 + gi * LANE_H)) &&
                         (y_ext <  11'(LANE_Y0 + (gi + 1) * LANE_H));
        assign lane_pix[gi] = video_on && in_rows && (dx < 11'(OBJ_W));
    end

    always_comb begin
        pix_on   = |lane_pix;
        pix_lane = 3'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_pix[i]) pix_lane = 3'(i);
        end
    end

    assign frog_box = (x_ext >= fx_ext) && (x_ext < fx_ext + 11'(FROG_SIZE)) &&
                      (y_ext >= fy_ext) && (y_ext < fy_ext + 11'(FROG_SIZE));

`ifdef DIFFICULTY_RAMP_EN
    logic [9:0] frame_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            extra     <= '0;
        end else if (state == PLAY && frame_tick) begin
            if (frame_cnt == 10'd599) begin
                frame_cnt <= '0;
                if (extra != 2'd3) extra <= extra + 2'd1;
            end else begin
                frame_cnt <= frame_cnt + 10'd1;
            end
        end else if (state == OVER && restart) begin
            frame_cnt <= '0;
            extra     <= '0;
        end
    end
`else
    assign extra = 2'd0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) lane_x[i] <= home_x(i);
            obj_on   <= 1'b0;
            obj_lane <= 3'd0;
            hit      <= 1'b0;
            lives    <= 2'(LIVES);
            state    <= PLAY;
            hit_cnt  <= '0;
            overlap  <= 1'b0;
        end else begin
            obj_on   <= pix_on;
            obj_lane <= pix_lane;
            hit      <= 1'b0;
            // The frame decision below reads overlap before this clear takes effect.
            overlap  <= frame_tick ? 1'b0 : (overlap | (pix_on & frog_box));

            case (state)
                PLAY: begin
                    if (frame_tick) begin
                        lane_x <= step_x;
                        if (overlap) begin
                            hit   <= 1'b1;
                            lives <= lives - 2'd1;
                            if (lives == 2'd1) begin
                                state <= OVER;
                            end else begin
                                state   <= HIT;
                                hit_cnt <= CNT_W'(HIT_FRAMES);
                            end
                        end
                    end
                end
                HIT: begin
                    if (frame_tick) begin
                        hit_cnt <= hit_cnt - CNT_W'(1);
                        if (hit_cnt == CNT_W'(1)) state <= PLAY;
                    end
                end
                OVER: begin
                    if (restart) begin
                        state <= PLAY;
                        lives <= 2'(LIVES);
                        for (int i = 0; i < NUM_LANES; i++) lane_x[i] <= home_x(i);
                    end
                end
                default: state <= PLAY;
            endcase
        end
    end

    assign freeze    = (state != PLAY);
    assign game_over = (state == OVER);

endmodule

// File: tb/tb_lane_obstacle_engine.sv
// Scoreboard bench for lane_obstacle_engine: pixel expectations queued at drive time, frame-level model per tick.
`timescale 1ns/1ps
module tb_lane_obstacle_engine;
    logic       clk = 1'b0;
    logic       reset, frame_tick, restart, video_on;
    logic [9:0] x, y, frog_x_l, frog_y_t;
    logic       obj_on, hit, freeze, game_over;
    logic [2:0] obj_lane;
    logic [1:0] lives;

    always #5 clk = ~clk;

    lane_obstacle_engine dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .restart(restart),
        .x(x), .y(y), .video_on(video_on), .frog_x_l(frog_x_l), .frog_y_t(frog_y_t),
        .obj_on(obj_on), .obj_lane(obj_lane), .hit(hit), .freeze(freeze),
        .lives(lives), .game_over(game_over)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_lane[4];
    int         m_state, m_lives, m_hcnt, m_extra, m_cnt, m_hit;
    bit         ov;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 4; l++) m_lane[l] = (l * 160) % 640;
        m_state = 0; m_lives = 3; m_hcnt = 0; m_extra = 0; m_cnt = 0; m_hit = 0; ov = 0;
    endtask

    task automatic model_tick(input bit ov_in, input bit rs);
        m_hit = 0;
        case (m_state)
            0: begin
                for (int l = 0; l < 4; l++) begin
                    if (l % 2 == 0) m_lane[l] = (m_lane[l] + 1 + l + m_extra) % 640;
                    else            m_lane[l] = (m_lane[l] - (1 + l + m_extra) + 640) % 640;
                end
`ifdef DIFFICULTY_RAMP_EN
                m_cnt++;
                if (m_cnt == 600) begin
                    m_cnt = 0;
                    if (m_extra < 3) m_extra++;
                end
`endif
                if (ov_in) begin
                    m_hit = 1;
                    m_lives--;
                    if (m_lives == 0) m_state = 2;
                    else begin m_state = 1; m_hcnt = 30; end
                end
            end
            1: begin
                m_hcnt--;
                if (m_hcnt == 0) m_state = 0;
            end
            default: begin
                if (rs) begin
                    m_state = 0; m_lives = 3; m_extra = 0; m_cnt = 0;
                    for (int l = 0; l < 4; l++) m_lane[l] = (l * 160) % 640;
                end
            end
        endcase
    endtask

    function automatic logic [3:0] model_pix(input int px, input int py, input bit vo);
        for (int l = 0; l < 4; l++) begin
            if (vo && py >= 292 + 32 * l && py < 292 + 32 * (l + 1) &&
                ((px - m_lane[l] + 640) % 640) < 64)
                return {1'b1, 3'(l)};
        end
        return 4'd0;
    endfunction

    task automatic check_state(input string tag);
        for (int l = 0; l < 4; l++)
            check($sformatf("%s lane%0d", tag, l), 32'(dut.lane_x[l]), m_lane[l]);
        check({tag, " lives"}, lives, m_lives);
        check({tag, " freeze"}, freeze, (m_state != 0));
        check({tag, " game_over"}, game_over, (m_state == 2));
    endtask

    task automatic pix(input int px, input int py, input bit vo);
        logic [3:0] e;
        @(negedge clk);
        x = 10'(px); y = 10'(py); video_on = vo;
        e = model_pix(px, py, vo);
        exp_q.push_back(e);
        if (e[3] && px >= int'(frog_x_l) && px < int'(frog_x_l) + 28 &&
            py >= int'(frog_y_t) && py < int'(frog_y_t) + 28)
            ov = 1;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        check($sformatf("pix x=%0d y=%0d", px, py), {obj_on, obj_lane}, e);
    endtask

    task automatic tick(input bit rs);
        @(negedge clk);
        video_on = 1'b0; frame_tick = 1'b1; restart = rs;
        @(posedge clk); #1;
        model_tick(ov, rs);
        ov = 0;
        check("tick hit", hit, m_hit);
        check_state("tick");
        @(negedge clk);
        frame_tick = 1'b0; restart = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; video_on = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic three_hits();
        for (int h = 0; h < 3; h++) begin
            frog_x_l = 10'(m_lane[0] % 600); frog_y_t = 10'd292;
            pix(int'(frog_x_l) + 3, 300, 1'b1);
            frog_x_l = 10'd320; frog_y_t = 10'd422;
            tick(1'b0);
            if (m_state == 1) repeat (30) tick(1'b0);
        end
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; restart = 1'b0; video_on = 1'b0;
        x = '0; y = '0; frog_x_l = 10'd320; frog_y_t = 10'd422;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset obj_on", obj_on, 0);
        check("reset obj_lane", obj_lane, 0);
        check("reset hit", hit, 0);
        check_state("reset");
        reset = 1'b0;

        // Occupancy around the reset positions.
        pix(10, 300, 1'b1);
        pix(70, 300, 1'b1);
        pix(10, 291, 1'b1);
        pix(10, 300, 1'b0);
        pix(170, 330, 1'b1);
        pix(490, 400, 1'b1);
        pix(10, 420, 1'b1);

        // First frame step.
        tick(1'b0);
        check("t1 lane0", 32'(dut.lane_x[0]), 1);
        check("t1 lane1", 32'(dut.lane_x[1]), 158);
        check("t1 lane2", 32'(dut.lane_x[2]), 323);
        check("t1 lane3", 32'(dut.lane_x[3]), 476);

        // Long run through the wrap points, scanning edge pixels when a lane is near a screen edge.
        for (int k = 0; k < 700; k++) begin
            tick(1'b0);
            for (int l = 0; l < 4; l++) begin
                if (m_lane[l] >= 630 || m_lane[l] < 10) begin
                    pix(0, 308 + 32 * l, 1'b1);
                    pix(639, 308 + 32 * l, 1'b1);
                    pix((m_lane[l] + 63) % 640, 308 + 32 * l, 1'b1);
                    pix((m_lane[l] + 64) % 640, 308 + 32 * l, 1'b1);
                end
            end
        end

        // Asynchronous reset in the middle of a clock period.
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("async lane0", 32'(dut.lane_x[0]), 0);
        check("async lane1", 32'(dut.lane_x[1]), 160);
        check("async lane3", 32'(dut.lane_x[3]), 480);
        check("async lives", lives, 3);
        check("async obj_on", obj_on, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Frog box edges are exclusive on the right/bottom side.
        frog_x_l = 10'd10; frog_y_t = 10'd301;
        pix(38, 310, 1'b1);
        pix(20, 300, 1'b1);
        tick(1'b0);

        // Single hit, HIT hold, resume.
        frog_x_l = 10'd0; frog_y_t = 10'd292;
        pix(5, 300, 1'b1);
        frog_x_l = 10'd320; frog_y_t = 10'd422;
        tick(1'b0);
        @(posedge clk); #1;
        check("hit pulse width", hit, 0);
        for (int k = 0; k < 30; k++) begin
            if (k == 15) begin
                frog_x_l = 10'(m_lane[0] % 600); frog_y_t = 10'd292;
                pix(int'(frog_x_l) + 2, 300, 1'b1);
                frog_x_l = 10'd320; frog_y_t = 10'd422;
            end
            tick(1'b0);
        end
        check("t4 freeze released", freeze, 0);
        tick(1'b0);

        // Three hits to game over, then restart behaviour.
        do_reset();
        three_hits();
        check("t5 over lives", lives, 0);
        check("t5 over flag", game_over, 1);
        frog_x_l = 10'(m_lane[0] % 600); frog_y_t = 10'd292;
        pix(int'(frog_x_l) + 2, 300, 1'b1);
        frog_x_l = 10'd320; frog_y_t = 10'd422;
        tick(1'b0);
        tick(1'b1);
        check("restart lane0", 32'(dut.lane_x[0]), 0);
        check("restart lane2", 32'(dut.lane_x[2]), 320);
        check("restart lives", lives, 3);
        tick(1'b1);
        check("restart in PLAY lane0", 32'(dut.lane_x[0]), 1);

`ifdef DIFFICULTY_RAMP_EN
        begin
            logic [10:0] prev3;
            do_reset();
            repeat (2450) tick(1'b0);
            prev3 = dut.lane_x[3];
            tick(1'b0);
            check("ramp lane3 step", 32'((int'(prev3) - int'(dut.lane_x[3]) + 640) % 640), 7);
            three_hits();
            tick(1'b1);
            tick(1'b0);
            check("ramp restart lane0", 32'(dut.lane_x[0]), 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
